// File: rtl/pc_unit_if.sv
// Fetch-stage control and handshake bundle between next-PC/hazard logic, pc_unit and imem.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              start_i;
    logic              stall_i;
    logic              redirect_valid_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              exc_i;
    logic              halt_i;
    logic              fetch_ready_i;
    logic              fetch_valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic [ADDR_W-1:0] pc_plus_o;
    logic              misalign_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output start_i, stall_i, redirect_valid_i, redirect_pc_i, exc_i, halt_i, fetch_ready_i,
        input  fetch_valid_o, pc_o, pc_plus_o, misalign_o, state_o, stall_cnt_o
    );

    modport slave (
        input  start_i, stall_i, redirect_valid_i, redirect_pc_i, exc_i, halt_i, fetch_ready_i,
        output fetch_valid_o, pc_o, pc_plus_o, misalign_o, state_o, stall_cnt_o
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: reset/exception vectors, redirect with alignment,
// halt/resume FSM and a saturating stall counter.
module pc_unit #(
    parameter int unsigned     ADDR_W      = 32,
    parameter int unsigned     INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_0080,
    parameter int unsigned     CNT_W       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pc_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        HALTED  = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    // Mask form keeps INSTR_BYTES=1 legal (no zero-width slice).
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_plus;

    assign pc_plus = pc_q + PC_INC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                if (bus.exc_i) begin
                    pc_d = EXC_VEC;
                end else begin
                    if (bus.redirect_valid_i) begin
                        pc_d  = bus.redirect_pc_i & ~ALIGN_MASK;
                        mis_d = |(bus.redirect_pc_i & ALIGN_MASK);
                    end else if (bus.stall_i) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    end else if (bus.fetch_ready_i) begin
                        pc_d = pc_plus;
                    end
                    if (bus.halt_i) state_d = HALTED;
                end
            end
            HALTED: begin
                if (bus.exc_i) begin
                    state_d = RUN;
                    pc_d    = EXC_VEC;
                end else if (bus.start_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fetch_valid_o = (state_q == RUN);
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus_o     = pc_plus;
    assign bus.misalign_o    = mis_q;
    assign bus.state_o       = state_q;
    assign bus.stall_cnt_o   = cnt_q;
endmodule
